// File: rtl/lstm_seq_pkg.sv
// Shared types and constants for the LSTM timestep sequencer.
// The state enum, default sizing and the per-timestep forward word count.
package lstm_seq_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    FEED_X   = 3'd1,
    FEED_H   = 3'd2,
    WAIT_OUT = 3'd3,
    DRAIN    = 3'd4,
    WAIT_T   = 3'd5
  } lstm_seq_state_e;

  localparam int DEF_WEIGHT_WORDS = 32;
  localparam int DEF_BIAS_WORDS   = 32;
  localparam int DEF_OUT_WORDS    = 8;
  localparam int DEF_CHUNK_W      = 6;

  // Words forwarded to the core in one timestep: every chunk is weights plus
  // one data word, and the first x chunk also carries the bias block.
  function automatic int step_words(input int weight_words, input int bias_words,
                                    input logic first_step, input int x_chunks,
                                    input int h_chunks);
    int chunk_len;
    chunk_len  = weight_words + 1;
    step_words = bias_words + x_chunks * chunk_len + (first_step ? 0 : h_chunks * chunk_len);
  endfunction

endpackage

// File: rtl/lstm_step_sequencer.sv
// Streams one LSTM timestep's host words into the core in chunk order, then
// drains the core's h_t words back to the host.
//
// state    | meaning
// IDLE     | waiting for start_i
// FEED_X   | forwarding x chunks (first one carries the bias block)
// FEED_H   | forwarding recurrent h chunks (skipped on timestep 0)
// WAIT_OUT | all words sent, waiting for core output
// DRAIN    | passing OUT_WORDS core output words to the host
// WAIT_T   | waiting for the core's timestep-complete flag
module lstm_step_sequencer
  import lstm_seq_pkg::*;
#(
  parameter int WEIGHT_WORDS = DEF_WEIGHT_WORDS,
  parameter int BIAS_WORDS   = DEF_BIAS_WORDS,
  parameter int OUT_WORDS    = DEF_OUT_WORDS,
  parameter int CHUNK_W      = DEF_CHUNK_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic               first_step_i,
  input  logic [CHUNK_W-1:0] x_chunks_i,
  input  logic [CHUNK_W-1:0] h_chunks_i,
  input  logic               abort_i,
  output logic               busy_o,
  output logic               done_o,
  output logic               err_o,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [31:0]        in_data_i,
  output logic               core_r_valid_o,
  output logic [31:0]        core_data_o,
  output logic               core_is_last_o,
  input  logic               core_r_data_i,
  input  logic               core_w_valid_i,
  input  logic [31:0]        core_out_data_i,
  output logic               core_out_pop_o,
  input  logic               core_t_valid_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [31:0]        out_data_o
);

  localparam int WCW = $clog2(WEIGHT_WORDS + BIAS_WORDS + 1);
  localparam int OCW = $clog2(OUT_WORDS + 1);
  localparam logic [WCW-1:0]     WORD_MAX  = WCW'(WEIGHT_WORDS + BIAS_WORDS);
  localparam logic [WCW-1:0]     CHUNK_END = WCW'(WEIGHT_WORDS);
  localparam logic [OCW-1:0]     OUT_END   = OCW'(OUT_WORDS - 1);
  localparam logic [CHUNK_W-1:0] CHUNK_MAX = '1;
  localparam logic [CHUNK_W-1:0] CHUNK_ONE = CHUNK_W'(1);

  lstm_seq_state_e    state_q, state_d;
  logic [WCW-1:0]     word_cnt_q, word_cnt_d;
  logic [CHUNK_W-1:0] chunk_cnt_q, chunk_cnt_d;
  logic [OCW-1:0]     out_cnt_q, out_cnt_d;
  logic               first_step_q, first_step_d;
  logic [CHUNK_W-1:0] x_chunks_q, x_chunks_d;
  logic [CHUNK_W-1:0] h_chunks_q, h_chunks_d;
  logic               is_last_q, is_last_d;
  logic               r_valid_q, r_valid_d;
  logic [31:0]        core_data_q, core_data_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic               busy_q, busy_d;

  logic           feeding, accept, chunk_done, last_x, last_h, final_chunk;
  logic [WCW-1:0] chunk_end_idx;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      word_cnt_q   <= '0;
      chunk_cnt_q  <= '0;
      out_cnt_q    <= '0;
      first_step_q <= 1'b0;
      x_chunks_q   <= '0;
      h_chunks_q   <= '0;
      is_last_q    <= 1'b0;
      r_valid_q    <= 1'b0;
      core_data_q  <= '0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      word_cnt_q   <= word_cnt_d;
      chunk_cnt_q  <= chunk_cnt_d;
      out_cnt_q    <= out_cnt_d;
      first_step_q <= first_step_d;
      x_chunks_q   <= x_chunks_d;
      h_chunks_q   <= h_chunks_d;
      is_last_q    <= is_last_d;
      r_valid_q    <= r_valid_d;
      core_data_q  <= core_data_d;
      done_q       <= done_d;
      err_q        <= err_d;
      busy_q       <= busy_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    word_cnt_d   = word_cnt_q;
    chunk_cnt_d  = chunk_cnt_q;
    out_cnt_d    = out_cnt_q;
    first_step_d = first_step_q;
    x_chunks_d   = x_chunks_q;
    h_chunks_d   = h_chunks_q;
    is_last_d    = is_last_q;
    r_valid_d    = 1'b0;
    core_data_d  = core_data_q;
    done_d       = 1'b0;
    err_d        = 1'b0;

    // Abort blocks handshakes in its own cycle so no word is half-consumed.
    feeding        = (state_q == FEED_X) || (state_q == FEED_H);
    in_ready_o     = feeding && core_r_data_i && !abort_i;
    accept         = in_ready_o && in_valid_i;
    out_valid_o    = (state_q == DRAIN) && core_w_valid_i;
    core_out_pop_o = out_valid_o && out_ready_i && !abort_i;
    out_data_o     = (state_q == DRAIN) ? core_out_data_i : '0;

    chunk_end_idx = (state_q == FEED_X && chunk_cnt_q == '0) ? WORD_MAX : CHUNK_END;
    chunk_done    = accept && (word_cnt_q == chunk_end_idx);
    last_x        = chunk_cnt_q == (x_chunks_q - CHUNK_ONE);
    last_h        = chunk_cnt_q == (h_chunks_q - CHUNK_ONE);
    final_chunk   = ((state_q == FEED_H) && last_h) ||
                    ((state_q == FEED_X) && first_step_q && last_x);

    if (accept) begin
      r_valid_d   = 1'b1;
      core_data_d = in_data_i;
      if (final_chunk && word_cnt_q == '0) is_last_d = 1'b1;
      if (chunk_done) begin
        word_cnt_d  = '0;
        chunk_cnt_d = (chunk_cnt_q == CHUNK_MAX) ? chunk_cnt_q : chunk_cnt_q + CHUNK_ONE;
      end else if (word_cnt_q != WORD_MAX) begin
        word_cnt_d = word_cnt_q + WCW'(1);
      end
    end

    case (state_q)
      IDLE: begin
        if (start_i) begin
          if (x_chunks_i == '0 || (!first_step_i && h_chunks_i == '0)) begin
            err_d = 1'b1;
          end else begin
            first_step_d = first_step_i;
            x_chunks_d   = x_chunks_i;
            h_chunks_d   = h_chunks_i;
            word_cnt_d   = '0;
            chunk_cnt_d  = '0;
            out_cnt_d    = '0;
            is_last_d    = 1'b0;
            state_d      = FEED_X;
          end
        end
      end
      FEED_X: begin
        if (chunk_done && last_x) begin
          chunk_cnt_d = '0;
          state_d     = first_step_q ? WAIT_OUT : FEED_H;
        end
      end
      FEED_H: begin
        if (chunk_done && last_h) begin
          chunk_cnt_d = '0;
          state_d     = WAIT_OUT;
        end
      end
      WAIT_OUT: if (core_w_valid_i) state_d = DRAIN;
      DRAIN: begin
        if (core_out_pop_o) begin
          if (out_cnt_q == OUT_END) begin
            out_cnt_d = '0;
            state_d   = WAIT_T;
          end else begin
            out_cnt_d = out_cnt_q + OCW'(1);
          end
        end
      end
      WAIT_T: begin
        if (core_t_valid_i) begin
          done_d    = 1'b1;
          is_last_d = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (start_i && state_q != IDLE) err_d = 1'b1;

    if (abort_i) begin
      state_d     = IDLE;
      word_cnt_d  = '0;
      chunk_cnt_d = '0;
      out_cnt_d   = '0;
      is_last_d   = 1'b0;
      done_d      = 1'b0;
      err_d       = 1'b0;
    end

    busy_d = (state_d != IDLE);
  end

  assign busy_o         = busy_q;
  assign done_o         = done_q;
  assign err_o          = err_q;
  assign core_r_valid_o = r_valid_q;
  assign core_data_o    = core_data_q;
  assign core_is_last_o = is_last_q;

endmodule

// File: tb/tb_lstm_step_sequencer.sv
// Randomized bench for lstm_step_sequencer: a host source, a core stub and a
// chunk-list reference model of the forwarded word stream.
module tb_lstm_step_sequencer;
  import lstm_seq_pkg::*;

  localparam int WW = 32;
  localparam int BW = 32;
  localparam int OW = 8;
  localparam int CW = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic          start_i, first_step_i, abort_i;
  logic [CW-1:0] x_chunks_i, h_chunks_i;
  logic          busy_o, done_o, err_o;
  logic          in_valid_i, in_ready_o;
  logic [31:0]   in_data_i;
  logic          core_r_valid_o, core_is_last_o, core_r_data_i;
  logic [31:0]   core_data_o;
  logic          core_w_valid_i, core_out_pop_o, core_t_valid_i;
  logic [31:0]   core_out_data_i;
  logic          out_valid_o, out_ready_i;
  logic [31:0]   out_data_o;

  always #5 clk = ~clk;

  lstm_step_sequencer #(
    .WEIGHT_WORDS(WW), .BIAS_WORDS(BW), .OUT_WORDS(OW), .CHUNK_W(CW)
  ) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .first_step_i(first_step_i),
    .x_chunks_i(x_chunks_i), .h_chunks_i(h_chunks_i), .abort_i(abort_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_data_i(in_data_i),
    .core_r_valid_o(core_r_valid_o), .core_data_o(core_data_o),
    .core_is_last_o(core_is_last_o), .core_r_data_i(core_r_data_i),
    .core_w_valid_i(core_w_valid_i), .core_out_data_i(core_out_data_i),
    .core_out_pop_o(core_out_pop_o), .core_t_valid_i(core_t_valid_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_data_o(out_data_o)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] src_q[$], recv_q[$], core_out_q[$], drained_q[$];
  int          exp_total, exp_last, last_idx, err_cnt, done_cnt;
  logic        timed_out, busy_seen, busy_at_done;
  logic [9:0]  snap;

  // Reference: list of chunk lengths for the timestep, summed.
  task automatic build_model(input bit first, input int x, input int h);
    int lens[$];
    lens.push_back(WW + 1 + BW);
    for (int i = 1; i < x; i++) lens.push_back(WW + 1);
    if (!first) for (int i = 0; i < h; i++) lens.push_back(WW + 1);
    exp_total = 0;
    foreach (lens[i]) exp_total += lens[i];
    exp_last = exp_total - lens[lens.size() - 1] + 1;
  endtask

  function automatic int mismatches(input logic [31:0] a[$], input logic [31:0] b[$]);
    int m = (a.size() > b.size()) ? a.size() - b.size() : b.size() - a.size();
    for (int i = 0; i < a.size() && i < b.size(); i++) if (a[i] !== b[i]) m++;
    return m;
  endfunction

  task automatic drive_idle();
    start_i = 0; abort_i = 0; first_step_i = 0; x_chunks_i = '0; h_chunks_i = '0;
    in_valid_i = 0; in_data_i = '0; core_r_data_i = 0; core_w_valid_i = 0;
    core_out_data_i = '0; core_t_valid_i = 0; out_ready_i = 0;
  endtask

  // One timestep: optional spurious start at cycle start_at, abort once
  // abort_at words were strobed, or async reset once rst_at_pop pops were made.
  task automatic run_step(input bit first, input int x, input int h, input bit gaps,
                          input int start_at, input int abort_at, input int rst_at_pop);
    int src_idx = 0, out_idx = 0;
    bit acc, pop, stop = 0;
    src_q.delete(); recv_q.delete(); core_out_q.delete(); drained_q.delete();
    last_idx = -1; err_cnt = 0; done_cnt = 0; timed_out = 0;
    busy_seen = 0; busy_at_done = 1'bx; snap = '0;
    build_model(first, x, h);
    for (int i = 0; i < exp_total; i++) src_q.push_back($urandom);
    for (int i = 0; i < OW; i++) core_out_q.push_back($urandom);
    @(posedge clk); #1;
    start_i = 1; first_step_i = first; x_chunks_i = CW'(x); h_chunks_i = CW'(h);
    for (int cyc = 0; cyc < 20000 && !stop; cyc++) begin
      in_valid_i      = (src_idx < exp_total) && (!gaps || $urandom_range(3) != 0);
      in_data_i       = (src_idx < exp_total) ? src_q[src_idx] : 32'h0;
      core_r_data_i   = !gaps || $urandom_range(3) != 0;
      out_ready_i     = !gaps || $urandom_range(1) != 0;
      core_w_valid_i  = (recv_q.size() == exp_total) && (out_idx < OW) &&
                        (!gaps || $urandom_range(2) != 0);
      core_out_data_i = (out_idx < OW) ? core_out_q[out_idx] : 32'h0;
      core_t_valid_i  = (out_idx == OW);
      @(negedge clk);
      if (err_o) err_cnt++;
      if (busy_o) busy_seen = 1;
      if (core_r_valid_o) recv_q.push_back(core_data_o);
      if (core_is_last_o && last_idx < 0) last_idx = recv_q.size();
      acc = in_valid_i && in_ready_o;
      pop = core_out_pop_o;
      if (pop) drained_q.push_back(out_data_o);
      if (done_o) begin
        done_cnt++; busy_at_done = busy_o; stop = 1;
      end
      @(posedge clk); #1;
      start_i = (cyc + 1 == start_at);
      if (acc) src_idx++;
      if (pop) out_idx++;
      if (!stop && abort_at > 0 && recv_q.size() >= abort_at) begin
        abort_i = 1;
        @(posedge clk); #1;
        abort_i = 0; in_valid_i = 1; core_r_data_i = 1;
        @(negedge clk);
        snap = {7'b0, busy_o, core_is_last_o, in_ready_o};
        stop = 1;
      end
      if (!stop && rst_at_pop > 0 && drained_q.size() >= rst_at_pop) begin
        rst = 0;
        #1;
        snap = {busy_o, done_o, err_o, in_ready_o, core_r_valid_o, core_is_last_o,
                core_out_pop_o, out_valid_o, core_data_o != 32'h0, out_data_o != 32'h0};
        repeat (2) @(posedge clk);
        #1 rst = 1;
        stop = 1;
      end
    end
    timed_out = !stop;
    drive_idle();
  endtask

  task automatic test_reset();
    drive_idle();
    rst = 0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({busy_o, done_o, err_o, core_is_last_o} !== 4'b0) begin
      n_fail++; $display("FAIL reset_flags got=%b want=0000", {busy_o, done_o, err_o, core_is_last_o});
    end
    n_checks++;
    if ({in_ready_o, core_r_valid_o, core_out_pop_o, out_valid_o} !== 4'b0) begin
      n_fail++; $display("FAIL reset_stream got=%b want=0000",
                         {in_ready_o, core_r_valid_o, core_out_pop_o, out_valid_o});
    end
    n_checks++;
    if (core_data_o !== 32'h0 || out_data_o !== 32'h0) begin
      n_fail++; $display("FAIL reset_data core=%h out=%h want=0", core_data_o, out_data_o);
    end
    @(posedge clk); #1 rst = 1;
  endtask

  task automatic test_first_step();
    run_step(1, 10, 0, 0, -1, 0, 0);
    n_checks++;
    if (recv_q.size() !== exp_total) begin
      n_fail++; $display("FAIL fs_strobes got=%0d want=%0d", recv_q.size(), exp_total);
    end
    n_checks++;
    if (mismatches(recv_q, src_q) !== 0) begin
      n_fail++; $display("FAIL fs_order got=%0d bad words want=0", mismatches(recv_q, src_q));
    end
    n_checks++;
    if (last_idx !== exp_last) begin
      n_fail++; $display("FAIL fs_is_last got=%0d want=%0d", last_idx, exp_last);
    end
    n_checks++;
    if (mismatches(drained_q, core_out_q) !== 0 || drained_q.size() !== OW) begin
      n_fail++; $display("FAIL fs_drain got=%0d words want=%0d", drained_q.size(), OW);
    end
    n_checks++;
    if (done_cnt !== 1 || timed_out !== 1'b0 || busy_at_done !== 1'b0 || err_cnt !== 0) begin
      n_fail++; $display("FAIL fs_done done=%0d timeout=%b busy=%b err=%0d want 1/0/0/0",
                         done_cnt, timed_out, busy_at_done, err_cnt);
    end
  endtask

  task automatic test_full_step();
    run_step(0, 10, 11, 0, -1, 0, 0);
    n_checks++;
    if (recv_q.size() !== exp_total || mismatches(recv_q, src_q) !== 0) begin
      n_fail++; $display("FAIL full_stream got=%0d words want=%0d", recv_q.size(), exp_total);
    end
    n_checks++;
    if (last_idx !== exp_last) begin
      n_fail++; $display("FAIL full_is_last got=%0d want=%0d", last_idx, exp_last);
    end
    n_checks++;
    if (mismatches(drained_q, core_out_q) !== 0 || drained_q.size() !== OW) begin
      n_fail++; $display("FAIL full_drain got=%0d words want=%0d", drained_q.size(), OW);
    end
    n_checks++;
    if (done_cnt !== 1 || timed_out !== 1'b0) begin
      n_fail++; $display("FAIL full_done got=%0d timeout=%b want 1/0", done_cnt, timed_out);
    end
  endtask

  task automatic test_random_gaps();
    for (int it = 0; it < 4; it++) begin
      bit first = (it == 0) ? 1'b0 : 1'($urandom_range(1));
      int x = (it == 0) ? 10 : $urandom_range(12, 1);
      int h = (it == 0) ? 11 : $urandom_range(12, 1);
      run_step(first, x, h, 1, -1, 0, 0);
      n_checks++;
      if (recv_q.size() !== exp_total || mismatches(recv_q, src_q) !== 0) begin
        n_fail++; $display("FAIL gaps_stream it=%0d got=%0d words (%0d bad) want=%0d",
                           it, recv_q.size(), mismatches(recv_q, src_q), exp_total);
      end
      n_checks++;
      if (last_idx !== exp_last || mismatches(drained_q, core_out_q) !== 0 || done_cnt !== 1) begin
        n_fail++; $display("FAIL gaps_tail it=%0d last=%0d want=%0d drained=%0d done=%0d",
                           it, last_idx, exp_last, drained_q.size(), done_cnt);
      end
    end
  endtask

  task automatic test_back_to_back();
    run_step(1, 2, 0, 0, -1, 0, 0);
    run_step(0, 1, 2, 0, -1, 0, 0);
    n_checks++;
    if (err_cnt !== 0 || done_cnt !== 1 || mismatches(recv_q, src_q) !== 0) begin
      n_fail++; $display("FAIL b2b got err=%0d done=%0d words=%0d want 0/1/%0d",
                         err_cnt, done_cnt, recv_q.size(), exp_total);
    end
  endtask

  task automatic test_start_errors();
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      start_i = 1; first_step_i = 1'(k); x_chunks_i = (k == 0) ? CW'(5) : CW'(0);
      h_chunks_i = '0;
      @(posedge clk); #1 start_i = 0;
      @(negedge clk);
      n_checks++;
      if (err_o !== 1'b1 || busy_o !== 1'b0) begin
        n_fail++; $display("FAIL bad_start k=%0d err=%b busy=%b want 1/0", k, err_o, busy_o);
      end
      @(negedge clk);
      n_checks++;
      if (err_o !== 1'b0 || busy_o !== 1'b0) begin
        n_fail++; $display("FAIL bad_start_after k=%0d err=%b busy=%b want 0/0", k, err_o, busy_o);
      end
    end
    run_step(1, 2, 0, 0, 20, 0, 0);
    n_checks++;
    if (err_cnt !== 1) begin
      n_fail++; $display("FAIL busy_start_err got=%0d pulses want=1", err_cnt);
    end
    n_checks++;
    if (recv_q.size() !== exp_total || mismatches(recv_q, src_q) !== 0 || done_cnt !== 1) begin
      n_fail++; $display("FAIL busy_start_progress got=%0d words done=%0d want=%0d/1",
                         recv_q.size(), done_cnt, exp_total);
    end
  endtask

  task automatic test_abort();
    run_step(1, 3, 0, 0, -1, 100, 0);
    n_checks++;
    if (last_idx !== exp_last) begin
      n_fail++; $display("FAIL abort_pre_last got=%0d want=%0d", last_idx, exp_last);
    end
    n_checks++;
    if (snap[2:0] !== 3'b000) begin
      n_fail++; $display("FAIL abort_state busy/last/ready got=%b want=000", snap[2:0]);
    end
    run_step(0, 2, 1, 0, -1, 0, 0);
    n_checks++;
    if (recv_q.size() !== exp_total || mismatches(recv_q, src_q) !== 0 || done_cnt !== 1) begin
      n_fail++; $display("FAIL abort_restart got=%0d words done=%0d want=%0d/1",
                         recv_q.size(), done_cnt, exp_total);
    end
  endtask

  task automatic test_reset_mid_drain();
    run_step(0, 2, 1, 0, -1, 0, 3);
    n_checks++;
    if (drained_q.size() !== 3 || snap !== 10'b0) begin
      n_fail++; $display("FAIL rst_drain outputs=%b pops=%0d want=0/3", snap, drained_q.size());
    end
    run_step(1, 1, 0, 0, -1, 0, 0);
    n_checks++;
    if (drained_q.size() !== OW || mismatches(drained_q, core_out_q) !== 0 || done_cnt !== 1) begin
      n_fail++; $display("FAIL rst_recover got=%0d drained done=%0d want=%0d/1",
                         drained_q.size(), done_cnt, OW);
    end
    n_checks++;
    if (last_idx !== exp_last || recv_q.size() !== exp_total) begin
      n_fail++; $display("FAIL rst_recover_stream last=%0d words=%0d want=%0d/%0d",
                         last_idx, recv_q.size(), exp_last, exp_total);
    end
  endtask

  initial begin
    test_reset();
    test_first_step();
    test_full_step();
    test_random_gaps();
    test_back_to_back();
    test_start_errors();
    test_abort();
    test_reset_mid_drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
